// File: rtl/bf16_pkg.sv
// Shared bf16 types and special-value encodings for the bf16 datapath.
// Used by the rounding unit, this packer and the bf16 multiplier path.
package bf16_pkg;

    typedef logic [15:0] bf16_t;
    typedef logic [31:0] fp32_t;

    localparam logic [14:0] BF16_QNAN_MAG = 15'h7FC0;
    localparam logic [14:0] BF16_INF_MAG  = 15'h7F80;

endpackage

// File: rtl/bf16_round.sv
// Combinational fp32 -> bf16 round-to-nearest-even with NaN/inf handling.
// o_ovf flags a finite input that rounded up into the infinity encoding.
module bf16_round
    import bf16_pkg::*;
(
    input  fp32_t i_fp32,
    output bf16_t o_bf16,
    output logic  o_ovf
);

    logic  w_isSpecial;
    logic  w_isNan;
    logic  w_roundUp;
    bf16_t w_rounded;

    assign w_isSpecial = &i_fp32[30:23];
    assign w_isNan     = w_isSpecial && (|i_fp32[22:0]);

    // Guard is bit 15, sticky is bits 14:0, and bit 16 breaks ties toward even.
    assign w_roundUp = i_fp32[15] & ((|i_fp32[14:0]) | i_fp32[16]);
    assign w_rounded = i_fp32[31:16] + {15'd0, w_roundUp};

    always_comb begin
        o_bf16 = w_rounded;
        if (w_isNan) begin
            o_bf16 = {i_fp32[31], BF16_QNAN_MAG};
        end else if (w_isSpecial) begin
            o_bf16 = {i_fp32[31], BF16_INF_MAG};
        end
    end

    assign o_ovf = !w_isSpecial && (&w_rounded[14:7]);

endmodule

// File: rtl/fp32_to_bf16_packer.sv
// Streaming fp32 -> bf16 down-converter that packs two rounded results per
// 32-bit output word and counts finite inputs that overflowed to infinity.
module fp32_to_bf16_packer
    import bf16_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [1:0]       out_keep,
    output logic             out_last,
    output logic [CNT_W-1:0] ovf_cnt
);

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_e;

    lane_e             r_lane;
    lane_e             w_laneNext;
    bf16_t             r_loQ;
    logic              r_outValid;
    logic [31:0]       r_outData;
    logic [1:0]        r_outKeep;
    logic              r_outLast;
    logic [CNT_W-1:0]  r_ovfCnt;

    bf16_t             w_rounded;
    logic              w_ovf;
    logic              w_xfer;
    logic              w_load;

    bf16_round u_round (
        .i_fp32 (in_data),
        .o_bf16 (w_rounded),
        .o_ovf  (w_ovf)
    );

    // A lane-0 element without in_last only touches r_loQ, so it may enter
    // while the output register is stalled; anything that loads it may not.
    assign in_ready = ((r_lane == LANE0) && !(in_last && out_valid && !out_ready))
                      || !out_valid || out_ready;
    assign w_xfer   = in_valid && in_ready;
    assign w_load   = w_xfer && ((r_lane == LANE1) || in_last);

    always_comb begin
        w_laneNext = r_lane;
        if (w_xfer) begin
            if (r_lane == LANE1) begin
                w_laneNext = LANE0;
            end else if (!in_last) begin
                w_laneNext = LANE1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane <= LANE0;
        end else begin
            r_lane <= w_laneNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_loQ <= '0;
        end else if (w_xfer && (r_lane == LANE0) && !in_last) begin
            r_loQ <= w_rounded;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outKeep  <= '0;
            r_outLast  <= 1'b0;
        end else if (w_load) begin
            r_outValid <= 1'b1;
            if (r_lane == LANE1) begin
                r_outData <= {w_rounded, r_loQ};
                r_outKeep <= 2'b11;
                r_outLast <= in_last;
            end else begin
                r_outData <= {16'h0000, w_rounded};
                r_outKeep <= 2'b01;
                r_outLast <= 1'b1;
            end
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovfCnt <= '0;
        end else if (w_xfer && w_ovf && !(&r_ovfCnt)) begin
            r_ovfCnt <= r_ovfCnt + 1'b1;
        end
    end

    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign out_keep  = r_outKeep;
    assign out_last  = r_outLast;
    assign ovf_cnt   = r_ovfCnt;

endmodule

// File: doc/fp32_to_bf16_packer.md
# fp32_to_bf16_packer

Streaming down-converter on the result path of the bf16 datapath. It accepts fp32 words, such as multiplier or accumulator outputs, through a valid/ready handshake. Each word is rounded to bf16 with round-to-nearest-even, and two consecutive results are packed into one 32-bit word for the bf16 write-back or memory interface. A saturating counter records how many finite inputs overflowed to infinity during rounding.

## Interface
- `CNT_W`, default 16: width of the overflow status counter.
- `clk` input 1: single clock; every register is clocked on its rising edge.
- `rst` input 1: reset, **asynchronous and active-high**.
- `in_valid` input 1: input word is valid.
- `in_ready` output 1: block can accept an input word.
- `in_data` input 32: fp32 value.
- `in_last` input 1: marks the final element of a stream; forces the partial word out.
- `out_valid` output 1: packed word is valid.
- `out_ready` input 1: downstream accepts the packed word.
- `out_data` output 32: packed word; `[15:0]` holds the earlier element (lane 0), `[31:16]` the later one (lane 1).
- `out_keep` output 2: lane-valid mask, either `2'b11` or `2'b01`.
- `out_last` output 1: this word ends the stream.
- `ovf_cnt` output CNT_W: count of finite→inf roundings; saturates at all-ones.

## Operation
- **Rounding**, applied per element with `f` = `in_data`:
  - `r = f[31:16]`.
  - Round up (`r+1`) when `f[15]=1` and either `f[14:0]!=0` or `f[16]=1`. This is RNE, with `f[15]` as the guard bit and `f[14:0]` as sticky.
  - A mantissa carry propagates into the exponent. Subnormal inputs use the same rule, so `0x007FFFFF` becomes `0x0080`.
- **Special values:**
  - Exponent 255 with mantissa 0 (infinity) passes through as `{s,0x7F80}`.
  - Exponent 255 with a nonzero mantissa (NaN) becomes `{s,0x7FC0}`.
  - Neither case counts as overflow.
- **Overflow counting:** a finite input whose rounded exponent becomes 255 increments `ovf_cnt`, which saturates.
- **Lane state:** 1-bit `lane`, reset to 0. `lo_q[15:0]` holds the pending lane-0 element.
- **Accept in lane 0:**
  - Without `in_last`: store the rounded value in `lo_q` and set `lane=1`.
  - With `in_last`: load the output register with `{16'h0,rounded}`, `keep=01`, `last=1`; `lane` stays 0.
- **Accept in lane 1:** load the output register with `{rounded,lo_q}`, `keep=11`, `last=in_last`, then set `lane=0`.
- **Handshake:**
  - `in_ready = (lane==0 && !(in_last && out_valid && !out_ready)) || !out_valid || out_ready`. This is combinational from `out_ready`.
  - A transfer occurs when `in_valid && in_ready`.
- **Output register:** while `out_valid && !out_ready`, `out_data`, `out_keep` and `out_last` hold stable. A simultaneous drain and load in the same cycle is legal and produces back-to-back words.
- **`in_last` in lane 1:** completes a full word with `out_last=1`.

## Timing
- Reset values:
  - `out_valid=0`, `out_data=0`, `out_keep=0`, `out_last=0`.
  - `lane=0`, `lo_q=0`, `ovf_cnt=0`.
  - `in_ready` comes up as 1.
- Latency: accept of a lane-1 element (or a lane-0 element with `in_last`) in cycle t gives `out_valid=1` in cycle t+1.
- Throughput: one element per cycle; one packed word every 2 cycles with no backpressure.
- `ovf_cnt` updates the cycle after the offending accept.
- Reset asserted mid-word discards the pending lane-0 element. A held output word is also dropped.
- `in_data` is ignored when there is no transfer. Glitches on `in_last` without `in_valid` have no effect.

## Structure
- Package `bf16_pkg`:
  - `typedef logic [15:0] bf16_t`, `typedef logic [31:0] fp32_t`.
  - Constants `BF16_QNAN_MAG=15'h7FC0`, `BF16_INF_MAG=15'h7F80`.
  - Shared with the bf16 multiplier path.
- Sub-module `bf16_round`: combinational fp32→bf16 RNE with special-value handling and an `ovf` flag. It is instantiated once and reused elsewhere.
- Top: lane FSM, `lo_q`, output register, and counter.

## Test plan
- Pair without backpressure:
  - `0x3F800000`, then `0x40000000` with `in_last`.
  - Expect `out_data=0x40003F80`, `keep=11`, `last=1`, one cycle after the second accept.
- Ties, each paired with a filler element:
  - `0x3F808000` → `0x3F80`.
  - `0x3F818000` → `0x3F82`.
  - `0x3F808001` → `0x3F81`.
- Specials:
  - `0x7F7FFFFF` → `0x7F80` and `ovf_cnt` goes 0→1.
  - `0x7F800000` → `0x7F80` and the count is unchanged.
  - `0xFF800001` → `0xFFC0`.
- Odd stream: a single `0xC0490FDB` with `in_last` → `out_data=0x0000C049`, `keep=01`, `last=1`.
- Backpressure:
  - Hold `out_ready=0` for 3 cycles with the stream `1.0,2.0,3.0,4.0`.
  - The word `0x40003F80` stays stable throughout.
  - `in_ready` drops for the lane-1 element.
  - The second word `0x40804040` follows with no loss or duplication.
- Reset mid-word:
  - Accept `0x3F800000`, then pulse `rst`.
  - All outputs go to 0.
  - The next pair `0x40000000`/`0x40400000` produces `0x40404000`.
